// File: rtl/wb_arbiter_2m_if.sv
// Wishbone B4 classic bus bundle. The master modport drives a cycle and the
// slave modport answers it.
interface wb_arbiter_2m_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic [AW-1:0]   adr;
  logic [DW-1:0]   dat_w;
  logic [DW/8-1:0] sel;
  logic            we;
  logic            cyc;
  logic            stb;
  logic [DW-1:0]   dat_r;
  logic            ack;
  logic            err;

  modport master (
    output adr, dat_w, sel, we, cyc, stb,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, dat_w, sel, we, cyc, stb,
    output dat_r, ack, err
  );
endinterface

// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone classic arbiter. Grants are round-robin and locked for the
// whole cyc tenure. A watchdog ends stalled strobes with an error.
module wb_arbiter_2m #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32
) (
  input  logic            clk,
  input  logic            rst,
  wb_arbiter_2m_if.slave  m0,
  wb_arbiter_2m_if.slave  m1,
  wb_arbiter_2m_if.master s,
  output logic [1:0]      grant,
  output logic            timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam int unsigned    WDW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t         state;
  logic           last_m1;
  logic [WDW-1:0] wd_cnt;

  logic            busy;
  logic            req0;
  logic            req1;
  logic            wd_fire;
  logic [AW-1:0]   g_adr;
  logic [DW-1:0]   g_dat;
  logic [DW/8-1:0] g_sel;
  logic            g_we;
  logic            g_cyc;
  logic            g_stb;

  assign busy = (state == BUSY);
  assign req0 = m0.cyc & m0.stb;
  assign req1 = m1.cyc & m1.stb;

  assign g_adr = grant[1] ? m1.adr   : m0.adr;
  assign g_dat = grant[1] ? m1.dat_w : m0.dat_w;
  assign g_sel = grant[1] ? m1.sel   : m0.sel;
  assign g_we  = grant[1] ? m1.we    : m0.we;
  assign g_cyc = grant[1] ? m1.cyc   : m0.cyc;
  assign g_stb = grant[1] ? m1.stb   : m0.stb;

  // An ack in the expiry cycle wins, so a late but valid response is never
  // turned into an error.
  assign wd_fire = (TIMEOUT != 0) && busy && g_stb && (wd_cnt == WD_LAST) &&
                   !s.ack && !s.err;

  // NOTE: the bus is gated by the state register rather than registered
  // itself. An asynchronous reset therefore drops cyc/stb at once,
  // not at the next edge.
  assign s.adr   = busy ? g_adr : '0;
  assign s.dat_w = busy ? g_dat : '0;
  assign s.sel   = busy ? g_sel : '0;
  assign s.we    = busy & g_we;
  assign s.cyc   = busy & g_cyc;
  assign s.stb   = busy & g_stb & ~wd_fire;

  assign m0.dat_r = s.dat_r;
  assign m1.dat_r = s.dat_r;
  assign m0.ack   = s.ack & grant[0];
  assign m1.ack   = s.ack & grant[1];
  assign m0.err   = (s.err | wd_fire) & grant[0] & ~s.ack;
  assign m1.err   = (s.err | wd_fire) & grant[1] & ~s.ack;
  assign timeout  = wd_fire;

  // NOTE: all state here uses non-blocking assignments, so every branch reads
  // the values from before the edge, whatever the statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= 2'b00;
      last_m1 <= 1'b1;
      wd_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (req0 || req1) begin
            state <= BUSY;
            // On a tie the master that did not hold the last tenure wins.
            if (req0 && (!req1 || last_m1)) grant <= 2'b01;
            else                            grant <= 2'b10;
          end
        end
        BUSY: begin
          if (!g_cyc) begin
            state   <= IDLE;
            grant   <= 2'b00;
            last_m1 <= grant[1];
            wd_cnt  <= '0;
          end else if (s.stb && !s.ack && !s.err) begin
            if (wd_cnt != WD_LAST) wd_cnt <= wd_cnt + WDW'(1);
          end else begin
            wd_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/wb_arbiter_2m.md
Name: wb_arbiter_2m

Overview:
Two-master Wishbone B4 classic arbiter. It shares the single SoC Wishbone bus, which feeds the address-decoding interconnect, between master 0 (core load/store controller) and master 1 (boot loader / DMA engine). Arbitration is round-robin with bus locking for the whole cyc assertion. A watchdog terminates stalled cycles with an error so that an unmapped or hung slave cannot freeze the pipeline.

Parameters:
TIMEOUT, 255, cycles stb may wait for ack/err before forced error; 0 disables watchdog
AW, 32, address width
DW, 32, data width

Ports:
wb_clk_i  input  1  system clock, all state on rising edge
wb_rst_i  input  1  reset, asynchronous, active-high
m0_adr_i / m1_adr_i  input  AW  master address
m0_dat_i / m1_dat_i  input  DW  master write data
m0_sel_i / m1_sel_i  input  DW/8  byte selects
m0_we_i / m1_we_i  input  1  write enable
m0_cyc_i / m1_cyc_i  input  1  cycle request/lock
m0_stb_i / m1_stb_i  input  1  strobe
m0_dat_o / m1_dat_o  output  DW  read data (both driven from s_dat_i)
m0_ack_o / m1_ack_o  output  1  ack, granted master only
m0_err_o / m1_err_o  output  1  error, granted master only
s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o  output  AW/DW/DW/8/1/1/1  slave-side bus to interconnect
s_dat_i  input  DW  slave read data
s_ack_i  input  1  slave ack
s_err_i  input  1  slave error
grant_o  output  2  one-hot current grant (debug/ILA), 2'b00 when idle
timeout_o  output  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset (asynchronous, immediate on wb_rst_i=1): state=IDLE, grant_o=00, last_grant=m1 (so m0 wins first tie), wd_cnt=0. All s_* outputs, acks, errs and timeout_o are 0. A mid-transfer reset drops s_cyc_o/s_stb_o in the same cycle. The slave ack is ignored.
- States: IDLE, BUSY.
- IDLE: request_n = mN_cyc_i & mN_stb_i. With one request, grant that master. With both, grant the master != last_grant. Grant is registered: BUSY starts on the next edge, giving 1 cycle of arbitration latency. No s_* activity in IDLE. All s_* outputs are 0.
- BUSY: s_adr/dat/sel/we/cyc mirror the granted master combinationally. s_stb_o = granted stb & ~wd_fire. Grant is held while the granted cyc_i=1, across any number of stb beats (locked RMW/bursts). The other master's requests wait, and it receives ack=err=0.
- Release: granted cyc_i=0 sampled -> next state IDLE, last_grant<=granted, grant_o<=00. A mandatory 1 idle cycle between tenures.
- Ack/err routing: mN_ack_o = s_ack_i & grant[N]; mN_err_o = (s_err_i | wd_fire) & grant[N] & ~s_ack_i.
- Watchdog: wd_cnt increments each BUSY cycle with s_stb_o=1 and s_ack_i=s_err_i=0. It clears on ack, err, stb low, or IDLE. wd_fire = (TIMEOUT!=0) & (wd_cnt==TIMEOUT-1) & no ack/err. On fire: one-cycle err to the master, timeout_o=1, s_stb_o=0 that cycle, wd_cnt<=0. It saturates and never wraps.
- Simultaneous ack and watchdog expiry: ack wins, no err, no timeout_o.
- s_ack_i and s_err_i both 1: ack delivered, err suppressed.
- Stray s_ack_i in IDLE is ignored.
- Granted master drops stb but keeps cyc: grant retained, no s_stb_o.

Test Plan:
- Single m0 read 0x0000_0010, slave acks 2 cycles after stb -> grant_o=01 one cycle after request, m0_ack_o 1 cycle, m0_dat_o=s_dat_i=0xDEADBEEF, m1_ack_o=0.
- Both request in the same cycle after reset -> m0 granted. After m0 drops cyc, IDLE 1 cycle, then m1 granted (grant_o 01->00->10).
- m0 holds cyc for 3 stb beats while m1 requests -> m1 is not granted until m0 cyc=0. s_adr_o never shows m1_adr_i during m0 tenure.
- TIMEOUT=4, slave never acks -> after stb has been high 4 cycles: m0_err_o=1 and timeout_o=1 for 1 cycle, s_stb_o=0 that cycle. TIMEOUT=0 -> no err after 1000 cycles.
- Ack arriving exactly on the expiry cycle -> ack only, err=0, timeout_o=0.
- Assert wb_rst_i mid-BUSY (asynchronous, between edges) -> s_cyc_o, s_stb_o, grant_o go 0 immediately. First request after reset release is arbitrated as fresh, with m0 priority.
